// File: rtl/warp_issue_scheduler_pkg.sv
// rtl/warp_issue_scheduler_pkg.sv - shared types for the warp issue scheduler
package sched_types;

  localparam int WARP_ID_W = 6;

  typedef logic [WARP_ID_W-1:0] warp_id_t;

  typedef enum logic [0:0] {
    SCHED_IDLE  = 1'b0,
    SCHED_ISSUE = 1'b1
  } sched_state_e;

endpackage

// File: rtl/warp_issue_scheduler_if.sv
// rtl/warp_issue_scheduler_if.sv - issue-slot interface between scheduler and execution unit
interface warp_issue_scheduler_if #(
  parameter int TPW = 32
);
  import sched_types::*;

  logic [31:0]    instruction_out;
  logic [TPW-1:0] thread_mask_out;
  warp_id_t       warp_id_out;
  logic           instruction_valid;
  logic           execution_ready;

  modport master (
    output instruction_out,
    output thread_mask_out,
    output warp_id_out,
    output instruction_valid,
    input  execution_ready
  );

  modport slave (
    input  instruction_out,
    input  thread_mask_out,
    input  warp_id_out,
    input  instruction_valid,
    output execution_ready
  );

endinterface

// File: rtl/warp_rr_picker.sv
// rtl/warp_rr_picker.sv - rotate-priority encoder: first eligible warp at or after rr_ptr
module warp_rr_picker
  import sched_types::*;
#(
  parameter int NUM_WARPS = 8
) (
  input  logic [NUM_WARPS-1:0] elig,
  input  warp_id_t             rr_ptr,
  output logic                 any_elig,
  output warp_id_t             pick_id
);

  logic [WARP_ID_W:0]   idx;
  logic [NUM_WARPS-1:0] shifted;

  // rr_ptr is always below NUM_WARPS, so one conditional subtract wraps the index
  always_comb begin
    any_elig = 1'b0;
    pick_id  = '0;
    idx      = '0;
    shifted  = '0;
    for (int i = 0; i < NUM_WARPS; i++) begin
      idx = {1'b0, rr_ptr} + (WARP_ID_W+1)'(i);
      if (idx >= (WARP_ID_W+1)'(NUM_WARPS)) begin
        idx = idx - (WARP_ID_W+1)'(NUM_WARPS);
      end
      shifted = elig >> idx[WARP_ID_W-1:0];
      if (!any_elig && shifted[0]) begin
        any_elig = 1'b1;
        pick_id  = idx[WARP_ID_W-1:0];
      end
    end
  end

endmodule

// File: rtl/warp_issue_scheduler.sv
// rtl/warp_issue_scheduler.sv - round-robin warp issue with barrier blocking
// Optional perf counters: define WARP_SCHED_PERF_EN.
module warp_issue_scheduler
  import sched_types::*;
#(
  parameter int NUM_WARPS        = 8,
  parameter int THREADS_PER_WARP = 32
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic [NUM_WARPS-1:0]                       warp_enable,
  input  logic [NUM_WARPS-1:0]                       fetch_valid,
  input  logic [NUM_WARPS-1:0][31:0]                 fetch_instr,
  input  logic [NUM_WARPS-1:0][THREADS_PER_WARP-1:0] fetch_mask,
  output logic [NUM_WARPS-1:0]                       fetch_pop,
  warp_issue_scheduler_if.master                     exec,
  input  logic                                       barrier_wait,
  input  warp_id_t                                   barrier_wait_warp,
  input  logic [NUM_WARPS-1:0]                       barrier_release,
  output logic [NUM_WARPS-1:0]                       warp_blocked,
  output logic [31:0]                                issue_count,
  output logic [31:0]                                stall_count
);

  localparam int IDX_W = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1;

  sched_state_e                state;
  logic [NUM_WARPS-1:0]        blocked;
  logic [NUM_WARPS-1:0]        elig;
  logic [NUM_WARPS-1:0]        wait_set;
  warp_id_t                    rr_ptr;
  warp_id_t                    pick_id;
  warp_id_t                    next_ptr;
  logic                        any_elig;
  logic                        accept;
  logic                        load;
  logic [IDX_W-1:0]            pick_sel;

  logic [31:0]                 instr_q;
  logic [THREADS_PER_WARP-1:0] mask_q;
  warp_id_t                    wid_q;
  logic                        valid_q;

  assign accept    = valid_q & exec.execution_ready;
  assign fetch_pop = accept ? (NUM_WARPS'(1) << wid_q) : '0;

  // The warp being popped this cycle has no new head yet, so it sits out this pick
  assign elig = warp_enable & fetch_valid & ~blocked & ~fetch_pop;

  warp_rr_picker #(
    .NUM_WARPS (NUM_WARPS)
  ) u_picker (
    .elig     (elig),
    .rr_ptr   (rr_ptr),
    .any_elig (any_elig),
    .pick_id  (pick_id)
  );

  assign pick_sel = pick_id[IDX_W-1:0];
  assign next_ptr = (pick_id == warp_id_t'(NUM_WARPS-1)) ? '0 : pick_id + warp_id_t'(1);

  // A fresh pick loads from IDLE, or in ISSUE only when the held one is accepted
  assign load = any_elig & ((state == SCHED_IDLE) | accept);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= SCHED_IDLE;
      valid_q <= 1'b0;
      instr_q <= '0;
      mask_q  <= '0;
      wid_q   <= '0;
      rr_ptr  <= '0;
    end else if (load) begin
      state   <= SCHED_ISSUE;
      valid_q <= 1'b1;
      instr_q <= fetch_instr[pick_sel];
      mask_q  <= fetch_mask[pick_sel];
      wid_q   <= pick_id;
      rr_ptr  <= next_ptr;
    end else if (accept) begin
      state   <= SCHED_IDLE;
      valid_q <= 1'b0;
    end
  end

  assign exec.instruction_out   = instr_q;
  assign exec.thread_mask_out   = mask_q;
  assign exec.warp_id_out       = wid_q;
  assign exec.instruction_valid = valid_q;

  // Out-of-range barrier warp ids are dropped; release overrides a same-cycle set
  assign wait_set = (barrier_wait && ({1'b0, barrier_wait_warp} < (WARP_ID_W+1)'(NUM_WARPS)))
                  ? (NUM_WARPS'(1) << barrier_wait_warp) : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      blocked <= '0;
    end else begin
      blocked <= (blocked | wait_set) & ~barrier_release;
    end
  end

  assign warp_blocked = blocked;

`ifdef WARP_SCHED_PERF_EN
  logic [31:0] issue_cnt;
  logic [31:0] stall_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      issue_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      if (accept && (issue_cnt != 32'hFFFF_FFFF)) begin
        issue_cnt <= issue_cnt + 32'd1;
      end
      if (valid_q && !exec.execution_ready && (stall_cnt != 32'hFFFF_FFFF)) begin
        stall_cnt <= stall_cnt + 32'd1;
      end
    end
  end

  assign issue_count = issue_cnt;
  assign stall_count = stall_cnt;
`else
  assign issue_count = '0;
  assign stall_count = '0;
`endif

endmodule
